// File: rtl/touch_zone_detector.sv
// Tests tracker pixels against NZONES rectangles, debounces presence per zone across frames, counts entries.
// Pixel hit: 1 cycle. Event and count: the cycle after frame_start. No backpressure; streaming input only.
module touch_zone_detector #(
  parameter int NZONES = 4,
  parameter int XW     = 10,
  parameter int YW     = 9,
  parameter int HOLD   = 3,
  parameter int CNTW   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [2:0]             cfg_zone,
  input  logic [XW-1:0]          cfg_x1,
  input  logic [XW-1:0]          cfg_x2,
  input  logic [YW-1:0]          cfg_y1,
  input  logic [YW-1:0]          cfg_y2,
  input  logic                   cnt_clr,
  input  logic                   frame_start,
  input  logic [1:0]             clcount,
  input  logic [XW-1:0]          tor_x,
  input  logic [YW-1:0]          tor_y,
  output logic [NZONES-1:0]      zone_hit,
  output logic                   outtd,
  output logic [NZONES-1:0]      zone_event,
  output logic [NZONES-1:0]      zone_active,
  output logic [NZONES*CNTW-1:0] zone_count
);

  typedef enum logic [1:0] {IDLE, ARM, ACTIVE, REL} state_t;

  state_t          st  [NZONES];
  logic [3:0]      run [NZONES];
  logic [CNTW-1:0] cnt [NZONES];
  logic [XW-1:0]   rx1 [NZONES];
  logic [XW-1:0]   rx2 [NZONES];
  logic [YW-1:0]   ry1 [NZONES];
  logic [YW-1:0]   ry2 [NZONES];

  logic [NZONES-1:0] seen;
  logic [NZONES-1:0] raw_hit;
  logic [NZONES-1:0] wr_sel;
  logic [NZONES-1:0] enter;

  // A disabled zone (x1>x2 or y1>y2) can never satisfy both inclusive bounds.
  always_comb begin
    raw_hit = '0;
    wr_sel  = '0;
    for (int i = 0; i < NZONES; i++) begin
      raw_hit[i] = (clcount == 2'd1) &&
                   (tor_x >= rx1[i]) && (tor_x <= rx2[i]) &&
                   (tor_y >= ry1[i]) && (tor_y <= ry2[i]);
      wr_sel[i]  = cfg_we && (int'(cfg_zone) == i);
    end
  end

  // Entry into ACTIVE; a rectangle write in the same cycle overrides the FSM.
  always_comb begin
    enter = '0;
    for (int i = 0; i < NZONES; i++) begin
      if (frame_start && !wr_sel[i] && seen[i]) begin
        case (st[i])
          IDLE:    enter[i] = (HOLD == 1);
          ARM:     enter[i] = ((run[i] + 4'd1) == 4'(HOLD));
          default: enter[i] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zone_hit   <= '0;
      outtd      <= 1'b0;
      zone_event <= '0;
      seen       <= '0;
      for (int i = 0; i < NZONES; i++) begin
        st[i]  <= IDLE;
        run[i] <= '0;
        cnt[i] <= '0;
        rx1[i] <= (i == 0) ? XW'(14)  : '1;
        rx2[i] <= (i == 0) ? XW'(156) : '0;
        ry1[i] <= (i == 0) ? YW'(11)  : '1;
        ry2[i] <= (i == 0) ? YW'(110) : '0;
      end
    end else begin
      zone_hit   <= raw_hit;
      outtd      <= |raw_hit;
      zone_event <= enter;
      for (int i = 0; i < NZONES; i++) begin
        if (cnt_clr)
          cnt[i] <= '0;
        else if (enter[i] && (cnt[i] != '1))
          cnt[i] <= cnt[i] + CNTW'(1);

        if (wr_sel[i]) begin
          rx1[i]  <= cfg_x1;
          rx2[i]  <= cfg_x2;
          ry1[i]  <= cfg_y1;
          ry2[i]  <= cfg_y2;
          st[i]   <= IDLE;
          run[i]  <= '0;
          seen[i] <= 1'b0;
        end else if (frame_start) begin
          // A hit coinciding with frame_start belongs to the new frame.
          seen[i] <= raw_hit[i];
          case (st[i])
            IDLE: if (seen[i]) begin
              if (HOLD == 1) begin
                st[i]  <= ACTIVE;
                run[i] <= '0;
              end else begin
                st[i]  <= ARM;
                run[i] <= 4'd1;
              end
            end
            ARM: if (seen[i]) begin
              if ((run[i] + 4'd1) == 4'(HOLD)) begin
                st[i]  <= ACTIVE;
                run[i] <= '0;
              end else begin
                run[i] <= run[i] + 4'd1;
              end
            end else begin
              st[i]  <= IDLE;
              run[i] <= '0;
            end
            ACTIVE: if (!seen[i]) begin
              if (HOLD == 1) begin
                st[i]  <= IDLE;
                run[i] <= '0;
              end else begin
                st[i]  <= REL;
                run[i] <= 4'd1;
              end
            end
            REL: if (!seen[i]) begin
              if ((run[i] + 4'd1) == 4'(HOLD)) begin
                st[i]  <= IDLE;
                run[i] <= '0;
              end else begin
                run[i] <= run[i] + 4'd1;
              end
            end else begin
              st[i]  <= ACTIVE;
              run[i] <= '0;
            end
            default: begin
              st[i]  <= IDLE;
              run[i] <= '0;
            end
          endcase
        end else begin
          seen[i] <= seen[i] | raw_hit[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NZONES; g++) begin : g_zone
    assign zone_active[g]             = (st[g] == ACTIVE) || (st[g] == REL);
    assign zone_count[g*CNTW +: CNTW] = cnt[g];
  end

endmodule

// File: tb/tb_touch_zone_detector.sv
// Directed bench for touch_zone_detector: pixel test, debounce, counting, reconfiguration, reset.
module tb_touch_zone_detector;

  localparam int NZONES = 4;
  localparam int XW     = 10;
  localparam int YW     = 9;
  localparam int HOLD   = 3;
  localparam int CNTW   = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   cfg_we;
  logic [2:0]             cfg_zone;
  logic [XW-1:0]          cfg_x1, cfg_x2;
  logic [YW-1:0]          cfg_y1, cfg_y2;
  logic                   cnt_clr;
  logic                   frame_start;
  logic [1:0]             clcount;
  logic [XW-1:0]          tor_x;
  logic [YW-1:0]          tor_y;
  logic [NZONES-1:0]      zone_hit;
  logic                   outtd;
  logic [NZONES-1:0]      zone_event;
  logic [NZONES-1:0]      zone_active;
  logic [NZONES*CNTW-1:0] zone_count;

  int n_tests = 0;
  int n_fail  = 0;

  touch_zone_detector #(
    .NZONES(NZONES), .XW(XW), .YW(YW), .HOLD(HOLD), .CNTW(CNTW)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_zone(cfg_zone),
    .cfg_x1(cfg_x1), .cfg_x2(cfg_x2), .cfg_y1(cfg_y1), .cfg_y2(cfg_y2),
    .cnt_clr(cnt_clr), .frame_start(frame_start), .clcount(clcount),
    .tor_x(tor_x), .tor_y(tor_y),
    .zone_hit(zone_hit), .outtd(outtd), .zone_event(zone_event),
    .zone_active(zone_active), .zone_count(zone_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One qualified pixel; outputs sampled 1 time unit after the capturing edge.
  task automatic pix(input int x, input int y, input int cl);
    tor_x   = XW'(x);
    tor_y   = YW'(y);
    clcount = 2'(cl);
    @(posedge clk); #1;
    clcount = 2'd0;
  endtask

  task automatic fs(input bit clr);
    frame_start = 1'b1;
    cnt_clr     = clr;
    @(posedge clk); #1;
    frame_start = 1'b0;
    cnt_clr     = 1'b0;
  endtask

  // One frame with a pixel inside (20,20) or far outside, then the closing frame_start.
  task automatic frame(input bit hit, input bit ev, input bit act, input string tag);
    if (hit) pix(20, 20, 1);
    else     pix(500, 300, 1);
    fs(1'b0);
    chk({tag, "_ev"},  32'(zone_event),  32'(ev));
    chk({tag, "_act"}, 32'(zone_active), 32'(act));
  endtask

  task automatic cfg(input int z, input int x1, input int x2, input int y1, input int y2,
                     input int px, input int py);
    cfg_we   = 1'b1;
    cfg_zone = 3'(z);
    cfg_x1   = XW'(x1);
    cfg_x2   = XW'(x2);
    cfg_y1   = YW'(y1);
    cfg_y2   = YW'(y2);
    pix(px, py, 1);
    cfg_we   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_zone = '0;
    cfg_x1 = '0; cfg_x2 = '0; cfg_y1 = '0; cfg_y2 = '0;
    cnt_clr = 1'b0; frame_start = 1'b0; clcount = '0; tor_x = '0; tor_y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hit",   32'(zone_hit),    32'h0);
    chk("rst_outtd", 32'(outtd),       32'h0);
    chk("rst_ev",    32'(zone_event),  32'h0);
    chk("rst_act",   32'(zone_active), 32'h0);
    chk("rst_cnt",   32'(zone_count),  32'h0);
    reset = 1'b0;

    // Default rectangle (14..156, 11..110), inclusive bounds.
    pix(14, 11, 1);   chk("t1_lo_corner", 32'(zone_hit), 32'h1); chk("t1_outtd1", 32'(outtd), 32'h1);
    pix(157, 110, 1); chk("t1_x_over",    32'(zone_hit), 32'h0); chk("t1_outtd0", 32'(outtd), 32'h0);
    pix(20, 20, 2);   chk("t1_clcount2",  32'(zone_hit), 32'h0);
    pix(156, 110, 1); chk("t1_hi_corner", 32'(zone_hit), 32'h1);
    pix(14, 10, 1);   chk("t1_y_under",   32'(zone_hit), 32'h0);
    // Hits above leave seen set: IDLE->ARM, then back to IDLE.
    frame(0, 0, 0, "t1_flush0");
    frame(0, 0, 0, "t1_flush1");

    // Three hit frames confirm entry.
    frame(1, 0, 0, "t2_f1");
    frame(1, 0, 0, "t2_f2");
    frame(1, 1, 1, "t2_f3");
    chk("t2_cnt", 32'(zone_count), 32'd1);
    @(posedge clk); #1;
    chk("t2_ev_one_cycle", 32'(zone_event), 32'h0);
    frame(1, 0, 1, "t2_f4");
    chk("t2_cnt_hold", 32'(zone_count), 32'd1);

    // Release debounce: a single hit after two misses keeps it active.
    frame(0, 0, 1, "t4_m1");
    frame(0, 0, 1, "t4_m2");
    frame(1, 0, 1, "t4_h1");
    frame(0, 0, 1, "t4_m3");
    frame(0, 0, 1, "t4_m4");
    frame(0, 0, 0, "t4_m5");
    chk("t4_cnt", 32'(zone_count), 32'd1);

    // Interrupted run: only the final three-frame run confirms.
    frame(1, 0, 0, "t3_h1");
    frame(1, 0, 0, "t3_h2");
    frame(0, 0, 0, "t3_miss");
    frame(1, 0, 0, "t3_h3");
    frame(1, 0, 0, "t3_h4");
    frame(1, 1, 1, "t3_h5");
    chk("t3_cnt", 32'(zone_count), 32'd2);
    for (int k = 0; k < 3; k++) frame(0, 0, k < 2, "t3_exit");

    // Saturation at 3 with a 2-bit counter.
    for (int e = 0; e < 2; e++) begin
      frame(1, 0, 0, "t6_a1");
      frame(1, 0, 0, "t6_a2");
      frame(1, 1, 1, "t6_a3");
      for (int k = 0; k < 3; k++) frame(0, 0, k < 2, "t6_exit");
    end
    chk("t6_sat", 32'(zone_count), 32'd3);

    // Clear coinciding with an entry event wins.
    frame(1, 0, 0, "t6_c1");
    frame(1, 0, 0, "t6_c2");
    pix(20, 20, 1);
    fs(1'b1);
    chk("t6_clr_ev",  32'(zone_event), 32'h1);
    chk("t6_clr_cnt", 32'(zone_count), 32'd0);
    for (int k = 0; k < 3; k++) frame(0, 0, k < 2, "t6_exit2");
    frame(1, 0, 0, "t6_d1");
    frame(1, 0, 0, "t6_d2");
    frame(1, 1, 1, "t6_d3");
    chk("t6_cnt_after_clr", 32'(zone_count), 32'd1);

    // Reprogramming: write cycle still uses the old rectangle and forces IDLE.
    cfg(0, 0, 10, 0, 10, 20, 20);
    chk("t5_old_rect",  32'(zone_hit),    32'h1);
    chk("t5_wr_idle",   32'(zone_active), 32'h0);
    cfg(1, 0, 0, 0, 0, 500, 300);
    pix(0, 0, 1);  chk("t5_both",  32'(zone_hit), 32'h3); chk("t5_outtd", 32'(outtd), 32'h1);
    pix(1, 0, 1);  chk("t5_z0",    32'(zone_hit), 32'h1);
    pix(20, 20, 1); chk("t5_none", 32'(zone_hit), 32'h0);
    cfg(1, 5, 4, 0, 0, 500, 300);
    pix(4, 0, 1);  chk("t5_dis4",  32'(zone_hit), 32'h1);
    pix(5, 0, 1);  chk("t5_dis5",  32'(zone_hit), 32'h1);

    // Asynchronous reset while zone 0 is arming.
    pix(5, 5, 1);
    fs(1'b0);
    pix(5, 5, 1);
    chk("t6_pre_rst_hit", 32'(zone_hit), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_hit",   32'(zone_hit),    32'h0);
    chk("t6_rst_outtd", 32'(outtd),       32'h0);
    chk("t6_rst_act",   32'(zone_active), 32'h0);
    chk("t6_rst_cnt",   32'(zone_count),  32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    pix(14, 11, 1); chk("t6_dflt_rect", 32'(zone_hit), 32'h1);
    pix(5, 5, 1);   chk("t6_dflt_out",  32'(zone_hit), 32'h0);
    pix(0, 0, 1);   chk("t6_z1_dis",    32'(zone_hit), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
